// File: rtl/gmii_tx_arbiter.sv
// Round-robin arbiter that shares one GMII transmit path between N_REQ frame
// sources. It prepends preamble and SFD, streams the owner's payload, turns a
// payload underrun into an error-marked abort, and enforces the inter-frame gap.
module gmii_tx_arbiter #(
  parameter int N_REQ     = 2,
  parameter int PRE_BYTES = 7,
  parameter int IFG_BYTES = 12
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  gmii_tx_rst,
  input  logic [N_REQ-1:0][7:0] req_dat,
  input  logic [N_REQ-1:0]      req_val,
  input  logic [N_REQ-1:0]      req_lst,
  output logic [N_REQ-1:0]      req_rdy,
  output logic [N_REQ-1:0]      gnt,
  output logic [7:0]            gmii_tx_dat,
  output logic                  gmii_tx_val,
  output logic                  gmii_tx_err,
  output logic                  busy,
  output logic                  underrun
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int CNT_MAX = (PRE_BYTES > IFG_BYTES) ? PRE_BYTES : IFG_BYTES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The IFG state is entered on the cycle that still shows the last data
  // byte after a normal end, but one cycle after the error byte after an
  // abort; the IDLE cycle that follows supplies the final idle byte.
  localparam int IFG_END_I = (IFG_BYTES > 1) ? IFG_BYTES - 1 : 0;
  localparam int IFG_ABT_I = (IFG_BYTES > 2) ? IFG_BYTES - 2 : 0;

  localparam logic [CNT_W-1:0] PRE_LOAD     = CNT_W'(PRE_BYTES - 1);
  localparam logic [CNT_W-1:0] IFG_LOAD_END = CNT_W'(IFG_END_I);
  localparam logic [CNT_W-1:0] IFG_LOAD_ABT = CNT_W'(IFG_ABT_I);

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, ABORT, IFG} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] last, last_n, pick;
  logic [N_REQ-1:0] gnt_n;

  logic [7:0]       tx_dat_p0;
  logic             tx_vld_p0;
  logic             tx_err_p0;
  logic             und_p0;

  logic             own_val;
  logic             own_lst;
  logic [7:0]       own_dat;
  logic             in_frame;

  // First requester with req_val set, searching from prev+1 upward, modulo N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] val,
                                               input logic [IDX_W-1:0] prev);
    logic [IDX_W-1:0] sel;
    logic             hit;
    int               idx;
    sel = prev;
    hit = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(prev) + i) % N_REQ;
      if (!hit && val[idx]) begin
        sel = IDX_W'(idx);
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [N_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // The owner index is the round-robin pointer itself: it is loaded with the winner.
  assign own_val  = req_val[last];
  assign own_lst  = req_lst[last];
  assign own_dat  = req_dat[last];
  assign in_frame = (state == PRE) || (state == SFD) || (state == DATA) || (state == ABORT);
  assign pick     = rr_pick(req_val, last);

  assign req_rdy  = ((state == SFD) || (state == DATA)) ? gnt : '0;
  assign busy     = (state != IDLE);

  // Next state, counters, grant and the byte to launch on the next cycle.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    last_n    = last;
    gnt_n     = gnt;
    tx_dat_p0 = 8'h00;
    tx_vld_p0 = 1'b0;
    tx_err_p0 = 1'b0;
    und_p0    = 1'b0;

    case (state)
      IDLE: begin
        if (!gmii_tx_rst && (|req_val)) begin
          state_n   = PRE;
          last_n    = pick;
          gnt_n     = to_onehot(pick);
          cnt_n     = PRE_LOAD;
          tx_dat_p0 = PRE_BYTE;
          tx_vld_p0 = 1'b1;
        end
      end
      PRE: begin
        tx_vld_p0 = 1'b1;
        if (cnt == '0) begin
          state_n   = SFD;
          tx_dat_p0 = SFD_BYTE;
        end else begin
          cnt_n     = cnt - 1'b1;
          tx_dat_p0 = PRE_BYTE;
        end
      end
      SFD, DATA: begin
        tx_vld_p0 = 1'b1;
        if (!own_val) begin
          state_n   = ABORT;
          tx_err_p0 = 1'b1;
          und_p0    = 1'b1;
        end else begin
          tx_dat_p0 = own_dat;
          if (own_lst) begin
            state_n = IFG;
            gnt_n   = '0;
            cnt_n   = IFG_LOAD_END;
          end else begin
            state_n = DATA;
          end
        end
      end
      ABORT: begin
        state_n = IFG;
        gnt_n   = '0;
        cnt_n   = IFG_LOAD_ABT;
      end
      IFG: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase

    // Adapter not ready: drop the frame at once, no abort marker, no gap.
    if (gmii_tx_rst && in_frame) begin
      state_n   = IDLE;
      gnt_n     = '0;
      tx_dat_p0 = 8'h00;
      tx_vld_p0 = 1'b0;
      tx_err_p0 = 1'b0;
      und_p0    = 1'b0;
    end
  end

  // State, pointer, grant and registered GMII outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= IDX_W'(N_REQ - 1);
      gnt         <= '0;
      gmii_tx_dat <= 8'h00;
      gmii_tx_val <= 1'b0;
      gmii_tx_err <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last        <= last_n;
      gnt         <= gnt_n;
      gmii_tx_dat <= tx_dat_p0;
      gmii_tx_val <= tx_vld_p0;
      gmii_tx_err <= tx_err_p0;
      underrun    <= und_p0;
    end
  end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter: per-requester byte sources, a queue of
// expected GMII beats and a queue of expected grants at each frame start.
module tb_gmii_tx_arbiter;

  localparam int N = 2;

  logic              clk = 1'b0;
  logic              arst;
  logic              gmii_tx_rst;
  logic [N-1:0][7:0] req_dat;
  logic [N-1:0]      req_val;
  logic [N-1:0]      req_lst;
  logic [N-1:0]      req_rdy;
  logic [N-1:0]      gnt;
  logic [7:0]        gmii_tx_dat;
  logic              gmii_tx_val;
  logic              gmii_tx_err;
  logic              busy;
  logic              underrun;

  always #5 clk = ~clk;

  gmii_tx_arbiter #(.N_REQ(N), .PRE_BYTES(7), .IFG_BYTES(12)) dut (
    .clk         (clk),
    .arst        (arst),
    .gmii_tx_rst (gmii_tx_rst),
    .req_dat     (req_dat),
    .req_val     (req_val),
    .req_lst     (req_lst),
    .req_rdy     (req_rdy),
    .gnt         (gnt),
    .gmii_tx_dat (gmii_tx_dat),
    .gmii_tx_val (gmii_tx_val),
    .gmii_tx_err (gmii_tx_err),
    .busy        (busy),
    .underrun    (underrun)
  );

  int           checks   = 0;
  int           errors   = 0;
  int           idle_run = 100;
  int           und_cnt  = 0;
  int           und_base = 0;
  logic         prev_val = 1'b0;
  logic         gap_chk  = 1'b1;

  logic [8:0]   exp_q[$];   // {err, dat} of each expected val=1 beat
  logic [N-1:0] gnt_q[$];   // expected gnt at each frame start
  logic [8:0]   src0_q[$];  // {lst, dat} waiting at requester 0
  logic [8:0]   src1_q[$];  // {lst, dat} waiting at requester 1

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_src();
    if (src0_q.size() > 0) begin
      req_val[0] = 1'b1; req_dat[0] = src0_q[0][7:0]; req_lst[0] = src0_q[0][8];
    end else begin
      req_val[0] = 1'b0; req_dat[0] = 8'h00; req_lst[0] = 1'b0;
    end
    if (src1_q.size() > 0) begin
      req_val[1] = 1'b1; req_dat[1] = src1_q[0][7:0]; req_lst[1] = src1_q[0][8];
    end else begin
      req_val[1] = 1'b0; req_dat[1] = 8'h00; req_lst[1] = 1'b0;
    end
  endtask

  task automatic push_pre();
    for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
  endtask

  // One clock: retire accepted source bytes, then check what the DUT shows.
  task automatic tick();
    logic [N-1:0] hs;
    logic [8:0]   e;
    drive_src();
    hs = req_val & req_rdy;
    @(posedge clk);
    #1;
    if (hs[0] && src0_q.size() > 0) void'(src0_q.pop_front());
    if (hs[1] && src1_q.size() > 0) void'(src1_q.pop_front());
    drive_src();
    if (gmii_tx_val) begin
      if (!prev_val) begin
        if (gap_chk) chk("ifg_gap_ge12", 32'(idle_run >= 12), 32'd1);
        if (gnt_q.size() > 0) chk("gnt_order", 32'(gnt), 32'(gnt_q.pop_front()));
      end
      chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tx_beat", 32'({gmii_tx_err, gmii_tx_dat}), 32'(e));
      end
      idle_run = 0;
    end else if (idle_run < 1000) begin
      idle_run++;
    end
    prev_val = gmii_tx_val;
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("rdy_owner_only", 32'(req_rdy & ~gnt), 32'd0);
    if (underrun) begin
      und_cnt++;
      chk("underrun_beat", 32'({gmii_tx_val, gmii_tx_err, gmii_tx_dat}), 32'h300);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tx"},       32'({gmii_tx_val, gmii_tx_err, gmii_tx_dat}), 32'd0);
    chk({tag, "_gnt"},      32'(gnt), 32'd0);
    chk({tag, "_rdy"},      32'(req_rdy), 32'd0);
    chk({tag, "_busy"},     32'(busy), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  task automatic wait_exp(input string tag, input int level, input int max);
    int n = 0;
    while (exp_q.size() > level && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(exp_q.size() <= level), 32'd1);
  endtask

  task automatic run_until_idle(input string tag, input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(exp_q.size() == 0 && !busy), 32'd1);
  endtask

  // Counts cycles after the last val=1 beat until busy falls.
  task automatic ifg_len(input string tag);
    int n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 32'(n >= 12 && n <= 13), 32'd1);
  endtask

  task automatic do_reset();
    arst = 1'b1;
    tick();
    arst = 1'b0;
  endtask

  initial begin
    arst        = 1'b1;
    gmii_tx_rst = 1'b0;
    req_val     = '0;
    req_dat     = '0;
    req_lst     = '0;
    #1;
    chk_zero("reset_async");
    repeat (3) tick();
    chk_zero("reset_held");
    arst = 1'b0;
    tick();
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Single 4-byte frame from requester 0.
    push_pre();
    exp_q.push_back(9'h011); exp_q.push_back(9'h022);
    exp_q.push_back(9'h033); exp_q.push_back(9'h044);
    src0_q.push_back(9'h011); src0_q.push_back(9'h022);
    src0_q.push_back(9'h033); src0_q.push_back(9'h144);
    wait_exp("t1_frame", 0, 40);
    ifg_len("t1_ifg_len");
    chk("t1_no_underrun", 32'(und_cnt), 32'd0);

    // Both requesters continuously valid, two 2-byte frames each.
    do_reset();
    gnt_q.push_back(2'b01); gnt_q.push_back(2'b10);
    gnt_q.push_back(2'b01); gnt_q.push_back(2'b10);
    push_pre(); exp_q.push_back(9'h0A0); exp_q.push_back(9'h0A1);
    push_pre(); exp_q.push_back(9'h0B0); exp_q.push_back(9'h0B1);
    push_pre(); exp_q.push_back(9'h0C0); exp_q.push_back(9'h0C1);
    push_pre(); exp_q.push_back(9'h0D0); exp_q.push_back(9'h0D1);
    src0_q.push_back(9'h0A0); src0_q.push_back(9'h1A1);
    src0_q.push_back(9'h0C0); src0_q.push_back(9'h1C1);
    src1_q.push_back(9'h0B0); src1_q.push_back(9'h1B1);
    src1_q.push_back(9'h0D0); src1_q.push_back(9'h1D1);
    run_until_idle("t2_arb", 300);
    chk("t2_all_grants_seen", 32'(gnt_q.size()), 32'd0);

    // Underrun: requester 1 stops after three bytes without lst.
    und_base = und_cnt;
    push_pre();
    exp_q.push_back(9'h0E1); exp_q.push_back(9'h0E2); exp_q.push_back(9'h0E3);
    exp_q.push_back(9'h100);
    src1_q.push_back(9'h0E1); src1_q.push_back(9'h0E2); src1_q.push_back(9'h0E3);
    wait_exp("t3_frame", 0, 40);
    ifg_len("t3_ifg_len");
    chk("t3_underrun_once", 32'(und_cnt - und_base), 32'd1);

    // Adapter not ready during the third preamble cycle.
    gap_chk  = 1'b0;
    und_base = und_cnt;
    src0_q.push_back(9'h05A); src0_q.push_back(9'h16B);
    for (int i = 0; i < 3; i++) exp_q.push_back(9'h055);
    wait_exp("t4_pre3", 0, 20);
    gmii_tx_rst = 1'b1;
    tick();
    chk("t4_val_drop", 32'({gmii_tx_val, gmii_tx_err}), 32'd0);
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_gnt", 32'(gnt), 32'd0);
    chk("t4_rdy", 32'(req_rdy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_no_grant", 32'({busy, gnt}), 32'd0);
    end
    chk("t4_no_underrun", 32'(und_cnt - und_base), 32'd0);
    push_pre(); exp_q.push_back(9'h05A); exp_q.push_back(9'h06B);
    gmii_tx_rst = 1'b0;
    run_until_idle("t4_restart", 60);
    gap_chk = 1'b1;

    // One-byte frame.
    push_pre(); exp_q.push_back(9'h0AB);
    src0_q.push_back(9'h1AB);
    wait_exp("t5_frame", 0, 40);
    ifg_len("t5_ifg_len");

    // Asynchronous reset in the middle of DATA.
    push_pre();
    exp_q.push_back(9'h001); exp_q.push_back(9'h002);
    exp_q.push_back(9'h003); exp_q.push_back(9'h004);
    src0_q.push_back(9'h001); src0_q.push_back(9'h002);
    src0_q.push_back(9'h003); src0_q.push_back(9'h104);
    wait_exp("t6_data", 2, 40);
    arst = 1'b1;
    #1;
    chk_zero("t6_arst_mid_data");
    exp_q.delete();
    src0_q.delete();
    tick();
    arst    = 1'b0;
    gap_chk = 1'b0;
    gnt_q.push_back(2'b01); gnt_q.push_back(2'b10);
    push_pre(); exp_q.push_back(9'h071);
    push_pre(); exp_q.push_back(9'h072);
    src0_q.push_back(9'h171);
    src1_q.push_back(9'h172);
    run_until_idle("t6_after_reset", 80);
    chk("t6_grants_seen", 32'(gnt_q.size()), 32'd0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
